bitonic_sort_engine: RTL

Parametrised, iterative bitonic sorter for the CSR space of the UDM-controlled SoC. It supersedes the fixed 8 x 32-bit sort CSR block and adds three things: configurable element count and width, a selectable sort direction, and an explicit start/busy/done handshake. The engine holds N elements in a register array and executes one bitonic stage per clock, performing N/2 compare-exchanges in parallel in each stage. The CSR decoder drives the write, start and read ports from UDM bus transactions.

---
 rtl/bitonic_pkg.sv | 21 ++
 rtl/bitonic_cmpx.sv | 30 +++
 rtl/bitonic_sort_engine.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bitonic_pkg.sv
// Shared types and constants for the bitonic sort engine.
// BITONIC_SIGNED_EN (see bitonic_cmpx) selects signed element comparison.
package bitonic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    // Number of bitonic stages for n elements: L(L+1)/2 with L = log2(n).
    function automatic int stage_count(input int n);
        int l;
        l = $clog2(n);
        return (l * (l + 1)) / 2;
    endfunction

endpackage

// File: rtl/bitonic_cmpx.sv
// Combinational compare-exchange of one element pair (lo goes to the lower index).
// Compile option BITONIC_SIGNED_EN: compare as two's-complement instead of unsigned.
module bitonic_cmpx #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          asc_i,
    output logic [DW-1:0] lo_o,
    output logic [DW-1:0] hi_o
);

    logic w_a_gt_b;
    logic w_a_lt_b;
    logic w_swap;

`ifdef BITONIC_SIGNED_EN
    assign w_a_gt_b = $signed(a_i) > $signed(b_i);
    assign w_a_lt_b = $signed(a_i) < $signed(b_i);
`else
    assign w_a_gt_b = a_i > b_i;
    assign w_a_lt_b = a_i < b_i;
`endif

    // Strict compares keep equal elements in place.
    assign w_swap = asc_i ? w_a_gt_b : w_a_lt_b;
    assign lo_o   = w_swap ? b_i : a_i;
    assign hi_o   = w_swap ? a_i : b_i;

endmodule

// File: rtl/bitonic_sort_engine.sv
// Iterative bitonic sorter: N-element register array, one stage (N/2 compare-exchanges) per clock.
// Compile option BITONIC_SIGNED_EN: signed element ordering (handled in bitonic_cmpx).
module bitonic_sort_engine
    import bitonic_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [$clog2(N)-1:0] wr_idx_i,
    input  logic [DW-1:0]        wr_data_i,
    input  logic                 start_i,
    input  logic                 dir_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sorted_o,
    output logic                 wr_err_o,
    input  logic [$clog2(N)-1:0] rd_idx_i,
    output logic [DW-1:0]        rd_data_o,
    output logic [1:0]           dbg_state_o
);

    localparam int LW = $clog2(N);
    localparam int NP = N / 2;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [DW-1:0]   r_mem [N];
    logic [LW:0]     r_k;
    logic [LW-1:0]   r_j;
    logic            r_dir;
    logic            r_done;
    logic            r_sorted;
    logic            r_wr_err;
    logic [DW-1:0]   r_rd_data;

    logic            w_busy;
    logic            w_last_stage;
    logic [LW-1:0]   w_jm;
    logic [LW-1:0]   w_p;
    logic [LW-1:0]   w_lo_idx [NP];
    logic [LW-1:0]   w_hi_idx [NP];
    logic [DW-1:0]   w_a      [NP];
    logic [DW-1:0]   w_b      [NP];
    logic [DW-1:0]   w_lo     [NP];
    logic [DW-1:0]   w_hi     [NP];
    logic            w_asc    [NP];
    logic [DW-1:0]   w_mem_nxt[N];

    // Pair p's lower index is p with a zero bit inserted at the position of j.
    always_comb begin
        w_jm = r_j - LW'(1);
        w_p  = '0;
        for (int p = 0; p < NP; p++) begin
            w_p         = LW'(p);
            w_lo_idx[p] = (w_p & w_jm) | ((w_p & ~w_jm) << 1);
            w_hi_idx[p] = w_lo_idx[p] | r_j;
            w_a[p]      = r_mem[w_lo_idx[p]];
            w_b[p]      = r_mem[w_hi_idx[p]];
            w_asc[p]    = ((({1'b0, w_lo_idx[p]}) & r_k) == '0) ^ (r_dir == DIR_DESC);
        end
    end

    for (genvar g = 0; g < NP; g++) begin : g_cmpx
        bitonic_cmpx #(.DW(DW)) u_cmpx (
            .a_i   (w_a[g]),
            .b_i   (w_b[g]),
            .asc_i (w_asc[g]),
            .lo_o  (w_lo[g]),
            .hi_o  (w_hi[g])
        );
    end

    always_comb begin
        w_mem_nxt = r_mem;
        for (int p = 0; p < NP; p++) begin
            w_mem_nxt[w_lo_idx[p]] = w_lo[p];
            w_mem_nxt[w_hi_idx[p]] = w_hi[p];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_busy       = 1'b0;
        w_last_stage = (r_k == (LW+1)'(N)) && (r_j == LW'(1));
        case (r_state)
            IDLE: begin
                if (start_i) w_state_nxt = SORT;
            end
            SORT: begin
                w_busy = 1'b1;
                if (w_last_stage) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_k       <= (LW+1)'(2);
            r_j       <= LW'(1);
            r_dir     <= DIR_ASC;
            r_done    <= 1'b0;
            r_sorted  <= 1'b0;
            r_wr_err  <= 1'b0;
            r_rd_data <= '0;
            for (int e = 0; e < N; e++) r_mem[e] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (r_state == DONE);
            r_wr_err  <= wr_en_i && (r_state != IDLE);
            r_rd_data <= r_mem[rd_idx_i];
            case (r_state)
                IDLE: begin
                    if (wr_en_i) begin
                        r_mem[wr_idx_i] <= wr_data_i;
                        r_sorted        <= 1'b0;
                    end
                    if (start_i) begin
                        r_dir <= dir_i;
                        r_k   <= (LW+1)'(2);
                        r_j   <= LW'(1);
                    end
                end
                SORT: begin
                    r_mem <= w_mem_nxt;
                    // After j==1 the next k-phase begins at j = k_new/2 = old k.
                    if (r_j == LW'(1)) begin
                        r_k <= r_k << 1;
                        r_j <= r_k[LW-1:0];
                    end else begin
                        r_j <= r_j >> 1;
                    end
                end
                DONE:    r_sorted <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy_o      = w_busy;
    assign done_o      = r_done;
    assign sorted_o    = r_sorted;
    assign wr_err_o    = r_wr_err;
    assign rd_data_o   = r_rd_data;
    assign dbg_state_o = r_state;

endmodule
